// File: rtl/cnn_multi_core.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_multi_core
//  Description : N lockstep mini-CNN cores; each does a 3x3 all-ones valid
//                convolution, optional ReLU (macro RELU_EN), global max pool.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn_multi_core #(
    parameter int N         = 4,
    parameter int IMG_SIZE  = 64,
    parameter int IMG_SIDE  = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N*IMG_SIZE*32-1:0]  input_images,
    output logic [N*OUT_WIDTH-1:0]    predictions,
    output logic                      all_done
);

    localparam int PIX_W = $clog2(IMG_SIZE);
    localparam int CNT_W = $clog2(IMG_SIDE);
    localparam logic [CNT_W-1:0] TAP_LAST = CNT_W'(2);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(IMG_SIDE - 3);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [N-1:0] done_vec;

    for (genvar c = 0; c < N; c++) begin : g_core
        state_t                 state, state_nxt;
        logic signed [31:0]     pix_buf [IMG_SIZE];
        logic [CNT_W-1:0]       win_r, win_c, tap_r, tap_c;
        logic signed [31:0]     acc, max_val;
        logic signed [31:0]     tap_px, win_sum, win_val, max_nxt;
        logic [PIX_W-1:0]       pix_idx;
        logic                   last_tap, last_win, first_win;
        logic [OUT_WIDTH-1:0]   pred;

        always_comb begin
            state_nxt = state;
            pix_idx   = PIX_W'(win_r + tap_r) * PIX_W'(IMG_SIDE) + PIX_W'(win_c + tap_c);
            tap_px    = pix_buf[pix_idx];
            last_tap  = (tap_r == TAP_LAST) && (tap_c == TAP_LAST);
            last_win  = (win_r == WIN_LAST) && (win_c == WIN_LAST);
            first_win = (win_r == '0) && (win_c == '0);
            win_sum   = acc + tap_px;
`ifdef RELU_EN
            win_val   = win_sum[31] ? '0 : win_sum;
`else
            win_val   = win_sum;
`endif
            // First window seeds the max regardless of the stale register value
            max_nxt   = (first_win || (win_val > max_val)) ? win_val : max_val;
            case (state)
                S_LOAD:  state_nxt = S_CONV;
                S_CONV:  if (last_tap && last_win) state_nxt = S_DONE;
                default: state_nxt = state;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst && state == S_LOAD) begin
                for (int p = 0; p < IMG_SIZE; p++) begin
                    pix_buf[p] <= input_images[(c*IMG_SIZE + p)*32 +: 32];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state   <= S_LOAD;
                win_r   <= '0;
                win_c   <= '0;
                tap_r   <= '0;
                tap_c   <= '0;
                acc     <= '0;
                max_val <= '0;
                pred    <= '0;
            end else begin
                state <= state_nxt;
                if (state == S_CONV) begin
                    if (last_tap) begin
                        acc     <= '0;
                        max_val <= max_nxt;
                        tap_r   <= '0;
                        tap_c   <= '0;
                        if (last_win) begin
                            pred <= OUT_WIDTH'(max_nxt);
                        end else if (win_c == WIN_LAST) begin
                            win_c <= '0;
                            win_r <= win_r + CNT_ONE;
                        end else begin
                            win_c <= win_c + CNT_ONE;
                        end
                    end else begin
                        acc <= win_sum;
                        if (tap_c == TAP_LAST) begin
                            tap_c <= '0;
                            tap_r <= tap_r + CNT_ONE;
                        end else begin
                            tap_c <= tap_c + CNT_ONE;
                        end
                    end
                end
            end
        end

        assign done_vec[c] = (state == S_DONE);
        // Gate with all_done so a result never appears ahead of the flag
        assign predictions[c*OUT_WIDTH +: OUT_WIDTH] = all_done ? pred : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            all_done <= 1'b0;
        end else begin
            all_done <= &done_vec;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnn_multi_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnn_multi_core
//  Description : Self-checking bench for cnn_multi_core (table + random runs).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_multi_core;

    localparam int N    = 4;
    localparam int SIZE = 64;
    localparam int SIDE = 8;
    localparam int OW   = 32;

    logic                   clk;
    logic                   rst;
    logic [N*SIZE*32-1:0]   images_bus;
    logic [N*OW-1:0]        predictions;
    logic                   all_done;

    logic [31:0] img [N][SIZE];
    int errors;
    int checks;

    typedef struct {
        int           pat;
        int           fill;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [4];

    cnn_multi_core #(
        .N        (N),
        .IMG_SIZE (SIZE),
        .IMG_SIDE (SIDE),
        .OUT_WIDTH(OW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .input_images(images_bus),
        .predictions (predictions),
        .all_done    (all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // pat 0: all fill; 1: core c = fill*(c+1); 2: core0 ramp, others fill;
    // 3: random small signed; 4: random full 32-bit
    task automatic set_images(input int pat, input int fill);
        for (int c = 0; c < N; c++) begin
            for (int p = 0; p < SIZE; p++) begin
                case (pat)
                    0:       img[c][p] = fill;
                    1:       img[c][p] = fill * (c + 1);
                    2:       img[c][p] = (c == 0) ? p : fill;
                    3:       img[c][p] = int'($urandom_range(0, 2000)) - 1000;
                    default: img[c][p] = $urandom;
                endcase
                images_bus[(c*SIZE + p)*32 +: 32] = img[c][p];
            end
        end
    endtask

    function automatic logic [31:0] model_pred(input int core);
        logic signed [31:0] best;
        logic signed [31:0] s;
        best = 0;
        for (int r = 0; r <= SIDE - 3; r++) begin
            for (int c = 0; c <= SIDE - 3; c++) begin
                s = 0;
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        s = s + img[core][(r + dr)*SIDE + c + dc];
`ifdef RELU_EN
                if (s < 0) s = 0;
`endif
                if ((r == 0 && c == 0) || s > best) best = s;
            end
        end
        return best;
    endfunction

    task automatic reset_dut(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_job(input string tag, input logic [127:0] exp,
                           input int change_at, input int change_fill);
        int cnt;
        logic partial;
        cnt = 0;
        partial = 1'b0;
        while (cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == change_at) set_images(0, change_fill);
            if (all_done) break;
            if (predictions !== '0) partial = 1'b1;
        end
        check({tag, "_latency"}, cnt, 326);
        check({tag, "_no_partial"}, {31'b0, partial}, 32'd0);
        for (int c = 0; c < N; c++)
            check($sformatf("%s_pred%0d", tag, c), predictions[c*OW +: OW], exp[c*32 +: 32]);
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_hold_done"}, {31'b0, all_done}, 32'd1);
        check({tag, "_hold_pred"}, predictions[31:0], exp[31:0]);
    endtask

    initial begin
        logic [127:0] exp;
        logic bad;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        images_bus = '0;

        vecs[0] = '{0, 1, {32'd9, 32'd9, 32'd9, 32'd9}};
        vecs[1] = '{1, 1, {32'd36, 32'd27, 32'd18, 32'd9}};
        vecs[2] = '{2, 1, {32'd9, 32'd9, 32'd9, 32'd486}};
`ifdef RELU_EN
        vecs[3] = '{0, -1, {32'd0, 32'd0, 32'd0, 32'd0}};
`else
        vecs[3] = '{0, -1, {32'hFFFFFFF7, 32'hFFFFFFF7, 32'hFFFFFFF7, 32'hFFFFFFF7}};
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset_done", {31'b0, all_done}, 32'd0);
        check("reset_pred", {31'b0, |predictions}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            set_images(vecs[i].pat, vecs[i].fill);
            reset_dut(2);
            run_job($sformatf("vec%0d", i), vecs[i].exp, -1, 0);
        end

        for (int i = 0; i < 3; i++) begin
            set_images((i == 2) ? 4 : 3, 0);
            for (int c = 0; c < N; c++) exp[c*32 +: 32] = model_pred(c);
            reset_dut(2);
            run_job($sformatf("rand%0d", i), exp, -1, 0);
        end

        // Inputs change after capture: result must reflect captured buffer
        set_images(0, 1);
        reset_dut(2);
        run_job("late_change", {4{32'd9}}, 50, 5);

        // Reset after completion clears outputs on the next edge
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_after_done_flag", {31'b0, all_done}, 32'd0);
        check("rst_after_done_pred", {31'b0, |predictions}, 32'd0);

        // Abort mid-run at cycle 100, then rerun with value 2
        set_images(0, 2);
        #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_flag", {31'b0, all_done}, 32'd0);
        check("abort_pred", {31'b0, |predictions}, 32'd0);
        rst = 1'b0;
        run_job("rerun", {4{32'd18}}, -1, 0);

        // Long reset with changing inputs; capture only after release
        set_images(0, 7);
        rst = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (all_done !== 1'b0 || predictions !== '0) bad = 1'b1;
        end
        check("long_reset_quiet", {31'b0, bad}, 32'd0);
        set_images(0, 3);
        rst = 1'b0;
        run_job("after_long_reset", {4{32'd27}}, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
